sigmoid_top_div_seq_30ns_15ns_15: RTL

Sequential unsigned restoring divider that inverts the 30-bit product format of the pipelined 15x15 multiplier. It divides a 30-bit dividend by a 15-bit divisor and returns a 15-bit quotient and 15-bit remainder. It feeds the reciprocal/normalisation step of the sigmoid datapath (1/(1+e^-x)) and produces one quotient bit per clock-enabled cycle. It uses a start/done handshake and the same `ce` stall semantics as the multiplier.

---
 rtl/sigmoid_top_div_seq_30ns_15ns_15.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_top_div_seq_30ns_15ns_15.sv
// Sequential unsigned restoring divider (30-bit / 15-bit) with start/done handshake and ce stall.
// Optional round-to-nearest quotient when SIGMOID_DIV_ROUND_EN is defined.
module sigmoid_top_div_seq_30ns_15ns_15 #(
    parameter int DIVIDEND_WIDTH = 30,
    parameter int DIVISOR_WIDTH  = 15,
    parameter int QUOTIENT_WIDTH = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      ready,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      ovf,
    output logic                      dbz
);

    localparam int CW = $clog2(QUOTIENT_WIDTH + 1);

    generate
        if (QUOTIENT_WIDTH != DIVIDEND_WIDTH - DIVISOR_WIDTH) begin : g_width_check
            $error("QUOTIENT_WIDTH must equal DIVIDEND_WIDTH - DIVISOR_WIDTH");
        end
    endgenerate

    // RESOLVE is a single settling cycle between the last quotient bit and the
    // result-valid cycle, giving QUOTIENT_WIDTH+1 enabled edges from accept to done.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                      state_r;
    logic [CW-1:0]               cnt_r;
    logic [DIVISOR_WIDTH:0]      rem_r;
    logic [QUOTIENT_WIDTH-1:0]   shift_r;
    logic [DIVISOR_WIDTH-1:0]    divisor_r;
    logic                        ovf_pend_r;
    logic                        dbz_pend_r;
    logic                        ready_r;
    logic                        done_r;
    logic [QUOTIENT_WIDTH-1:0]   quotient_r;
    logic [DIVISOR_WIDTH-1:0]    remainder_r;
    logic                        ovf_r;
    logic                        dbz_r;

    logic [DIVISOR_WIDTH+1:0]    trial_s;
    logic [DIVISOR_WIDTH:0]      diff_s;
    logic [DIVISOR_WIDTH:0]      rem_next_s;
    logic                        qbit_s;
    logic [QUOTIENT_WIDTH-1:0]   q_res_s;
    logic [DIVISOR_WIDTH-1:0]    r_res_s;
    logic [DIVISOR_WIDTH-1:0]    dvd_hi_s;
    logic                        dbz_in_s;
    logic                        ovf_in_s;

`ifdef SIGMOID_DIV_ROUND_EN
    // Round half-up on the truncated quotient, saturating at all ones.
    function automatic logic [QUOTIENT_WIDTH-1:0] round_quot(
        input logic [QUOTIENT_WIDTH-1:0] q,
        input logic [DIVISOR_WIDTH-1:0]  r,
        input logic [DIVISOR_WIDTH-1:0]  d
    );
        logic [DIVISOR_WIDTH:0] twice;
        twice = {r, 1'b0};
        if ((twice >= {1'b0, d}) && (q != {QUOTIENT_WIDTH{1'b1}})) begin
            round_quot = q + {{(QUOTIENT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            round_quot = q;
        end
    endfunction
`endif

    // Operand decode for the flags evaluated on the accepting edge.
    always_comb begin
        dvd_hi_s = dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
        dbz_in_s = (divisor == {DIVISOR_WIDTH{1'b0}});
        ovf_in_s = !dbz_in_s && (dvd_hi_s >= divisor);
    end

    // One restoring step: shift in the next dividend bit and conditionally subtract.
    always_comb begin
        trial_s    = {rem_r, shift_r[QUOTIENT_WIDTH-1]};
        diff_s     = trial_s[DIVISOR_WIDTH:0] - {1'b0, divisor_r};
        rem_next_s = trial_s[DIVISOR_WIDTH:0];
        qbit_s     = 1'b0;
        if (trial_s >= {2'b00, divisor_r}) begin
            rem_next_s = diff_s;
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = trial_s[DIVISOR_WIDTH:0];
            qbit_s     = 1'b0;
        end
    end

    // Final result selection with divide-by-zero taking priority over overflow.
    always_comb begin
        q_res_s = shift_r;
        r_res_s = rem_r[DIVISOR_WIDTH-1:0];
        if (dbz_pend_r || ovf_pend_r) begin
            q_res_s = {QUOTIENT_WIDTH{1'b1}};
            r_res_s = {DIVISOR_WIDTH{1'b0}};
        end else begin
`ifdef SIGMOID_DIV_ROUND_EN
            q_res_s = round_quot(shift_r, rem_r[DIVISOR_WIDTH-1:0], divisor_r);
`else
            q_res_s = shift_r;
`endif
            r_res_s = rem_r[DIVISOR_WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs; ce low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= {(DIVISOR_WIDTH+1){1'b0}};
            shift_r     <= {QUOTIENT_WIDTH{1'b0}};
            divisor_r   <= {DIVISOR_WIDTH{1'b0}};
            ovf_pend_r  <= 1'b0;
            dbz_pend_r  <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            quotient_r  <= {QUOTIENT_WIDTH{1'b0}};
            remainder_r <= {DIVISOR_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        rem_r      <= {1'b0, dvd_hi_s};
                        shift_r    <= dividend[QUOTIENT_WIDTH-1:0];
                        divisor_r  <= divisor;
                        cnt_r      <= CW'(QUOTIENT_WIDTH - 1);
                        dbz_pend_r <= dbz_in_s;
                        ovf_pend_r <= ovf_in_s;
                        ready_r    <= 1'b0;
                        state_r    <= ST_CALC;
                    end else begin
                        ready_r    <= 1'b1;
                    end
                end
                ST_CALC: begin
                    rem_r   <= rem_next_s;
                    shift_r <= {shift_r[QUOTIENT_WIDTH-2:0], qbit_s};
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_RESOLVE;
                    end else begin
                        cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESOLVE: begin
                    quotient_r  <= q_res_s;
                    remainder_r <= r_res_s;
                    dbz_r       <= dbz_pend_r;
                    ovf_r       <= ovf_pend_r && !dbz_pend_r;
                    done_r      <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign ovf       = ovf_r;
    assign dbz       = dbz_r;

endmodule
